// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the RV32 pipeline controller: opcodes, ALU codes,
// branch funct3 codes, the per-stage control bundle and small helpers.
package core_ctrl_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic [4:0] rd;
        logic       memwrite;
        logic       memtoreg;
        logic       wbsel;
        logic       alusrc;
        logic [2:0] aluctl;
        logic       branch;
        logic [2:0] funct3;
        logic       jump;
        logic       jal;
    } ctrl_t;

    // flags: [3]N [2]Z [1]C [0]V, C set means no borrow
    function automatic logic branch_taken(input logic [2:0] funct3, input logic [3:0] flags);
        logic n, z, c, v;
        {n, z, c, v} = flags;
        case (funct3)
            F3_BEQ:  return z;
            F3_BNE:  return !z;
            F3_BLT:  return n ^ v;
            F3_BGE:  return !(n ^ v);
            F3_BLTU: return !c;
            F3_BGEU: return c;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic raw_hit(input ctrl_t c, input logic [4:0] rs);
        return c.valid && c.regwrite && (rs != 5'd0) && (c.rd == rs);
    endfunction

endpackage

// File: rtl/core_ctrl_decode.sv
// DEC-stage decoder: instruction word to control bundle, immediate-form
// selects and register-read usage. Unsupported encodings become bubbles.
module core_ctrl_decode
    import core_ctrl_pkg::*;
(
    input  logic [31:0] instr_d,
    output ctrl_t       ctrl,
    output logic        s0,
    output logic        s9,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic        rs1_used,
    output logic        rs2_used
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       unused_instr;

    assign opcode       = instr_d[6:0];
    assign funct3       = instr_d[14:12];
    assign funct7_5     = instr_d[30];
    assign rs1          = instr_d[19:15];
    assign rs2          = instr_d[24:20];
    assign unused_instr = ^{instr_d[31], instr_d[29:25]};

    always_comb begin
        ctrl        = '0;
        s0          = 1'b0;
        s9          = 1'b0;
        rs1_used    = 1'b0;
        rs2_used    = 1'b0;
        ctrl.rd     = instr_d[11:7];
        ctrl.funct3 = funct3;
        case (opcode)
            OPC_OP, OPC_OP_IMM: begin
                ctrl.valid    = 1'b1;
                ctrl.regwrite = 1'b1;
                ctrl.wbsel    = 1'b1;
                ctrl.alusrc   = (opcode == OPC_OP_IMM);
                rs1_used      = 1'b1;
                rs2_used      = (opcode == OPC_OP);
                case (funct3)
                    3'b000: ctrl.aluctl = (opcode == OPC_OP && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b001: ctrl.aluctl = ALU_SLL;
                    3'b010: ctrl.aluctl = ALU_SLT;
                    3'b100: ctrl.aluctl = ALU_XOR;
                    3'b101: begin
                        ctrl.aluctl = ALU_SRL;
                        if (funct7_5) ctrl.valid = 1'b0;
                    end
                    3'b110: ctrl.aluctl = ALU_OR;
                    3'b111: ctrl.aluctl = ALU_AND;
                    default: ctrl.valid = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                ctrl.valid    = 1'b1;
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = 1'b1;
                ctrl.wbsel    = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.aluctl   = ALU_ADD;
                rs1_used      = 1'b1;
            end
            OPC_STORE: begin
                ctrl.valid    = 1'b1;
                ctrl.memwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.aluctl   = ALU_ADD;
                s0            = 1'b1;
                rs1_used      = 1'b1;
                rs2_used      = 1'b1;
            end
            OPC_BRANCH: begin
                ctrl.valid  = 1'b1;
                ctrl.branch = 1'b1;
                ctrl.aluctl = ALU_SUB;
                s0          = 1'b1;
                rs1_used    = 1'b1;
                rs2_used    = 1'b1;
            end
            OPC_JAL: begin
                ctrl.valid    = 1'b1;
                ctrl.regwrite = 1'b1;
                ctrl.jump     = 1'b1;
                ctrl.jal      = 1'b1;
                s9            = 1'b1;
            end
            OPC_JALR: begin
                ctrl.valid    = 1'b1;
                ctrl.regwrite = 1'b1;
                ctrl.jump     = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.aluctl   = ALU_ADD;
                rs1_used      = 1'b1;
            end
            default: ctrl.valid = 1'b0;
        endcase
        // Invalid encodings must not leak selects or read usage into hazard logic
        if (!ctrl.valid) begin
            ctrl     = '0;
            s0       = 1'b0;
            s9       = 1'b0;
            rs1_used = 1'b0;
            rs2_used = 1'b0;
        end
    end

endmodule

// File: rtl/core_ctrl.sv
// Five-stage pipeline controller: stage control registers, RAW scoreboard,
// branch resolution and stall/flush. CORE_CTRL_PERF_EN adds perf counters.
module core_ctrl
    import core_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_d,
    input  logic [3:0]  flags_m,
    output logic        s0,
    output logic        s9,
    output logic        s3,
    output logic [2:0]  s4,
    output logic        s1,
    output logic        s5,
    output logic        s6,
    output logic        s7,
    output logic        s8,
    output logic        s2,
    output logic        stall_f,
    output logic        stall_d,
    output logic        flush_d,
    output logic        flush_e,
    output logic        flush_m
`ifdef CORE_CTRL_PERF_EN
    ,
    output logic [31:0] perf_cycles,
    output logic [31:0] perf_retired,
    output logic [31:0] perf_stalls,
    output logic [31:0] perf_flushes
`endif
);

    ctrl_t      ctrl_d, ctrl_e, ctrl_m, ctrl_w;
    logic       dec_s0, dec_s9;
    logic [4:0] rs1, rs2;
    logic       rs1_used, rs2_used;
    logic       hazard, redirect, stall;
    logic       unused_w;

    core_ctrl_decode u_decode (
        .instr_d  (instr_d),
        .ctrl     (ctrl_d),
        .s0       (dec_s0),
        .s9       (dec_s9),
        .rs1      (rs1),
        .rs2      (rs2),
        .rs1_used (rs1_used),
        .rs2_used (rs2_used)
    );

    assign hazard = (rs1_used && (raw_hit(ctrl_e, rs1) || raw_hit(ctrl_m, rs1) || raw_hit(ctrl_w, rs1)))
                 || (rs2_used && (raw_hit(ctrl_e, rs2) || raw_hit(ctrl_m, rs2) || raw_hit(ctrl_w, rs2)));

    assign redirect = ctrl_m.valid && (ctrl_m.jump || (ctrl_m.branch && branch_taken(ctrl_m.funct3, flags_m)));
    assign stall    = hazard && !redirect;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_e <= '0;
            ctrl_m <= '0;
            ctrl_w <= '0;
        end else begin
            ctrl_e <= (stall || redirect) ? '0 : ctrl_d;
            ctrl_m <= redirect ? '0 : ctrl_e;
            ctrl_w <= ctrl_m;
        end
    end

    // DEC selects are combinational from instr_d, so reset must mask them directly
    assign s0 = dec_s0 && !reset;
    assign s9 = dec_s9 && !reset;

    assign s3 = ctrl_e.valid && ctrl_e.alusrc;
    assign s4 = ctrl_e.valid ? ctrl_e.aluctl : '0;

    assign s1 = redirect;
    assign s5 = ctrl_m.valid && ctrl_m.memwrite;
    assign s6 = ctrl_m.valid && (ctrl_m.branch || ctrl_m.jal);

    assign s7 = ctrl_w.valid && ctrl_w.memtoreg;
    assign s8 = ctrl_w.valid && ctrl_w.wbsel;
    assign s2 = ctrl_w.valid && ctrl_w.regwrite && (ctrl_w.rd != 5'd0);

    assign stall_f = stall;
    assign stall_d = stall;
    assign flush_d = redirect;
    assign flush_e = redirect || stall;
    assign flush_m = redirect;

    assign unused_w = ^ctrl_w;

`ifdef CORE_CTRL_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_cycles  <= '0;
            perf_retired <= '0;
            perf_stalls  <= '0;
            perf_flushes <= '0;
        end else begin
            perf_cycles <= perf_cycles + 32'd1;
            if (ctrl_w.valid) perf_retired <= perf_retired + 32'd1;
            if (stall)        perf_stalls  <= perf_stalls + 32'd1;
            if (redirect)     perf_flushes <= perf_flushes + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_core_ctrl.sv
// Self-checking bench for core_ctrl: directed scenarios plus random
// instruction streams checked against an instruction-level pipeline model.
module tb_core_ctrl;

    localparam bit [6:0] OP_R  = 7'b0110011;
    localparam bit [6:0] OP_I  = 7'b0010011;
    localparam bit [6:0] OP_LD = 7'b0000011;
    localparam bit [6:0] OP_ST = 7'b0100011;
    localparam bit [6:0] OP_BR = 7'b1100011;
    localparam bit [6:0] OP_JL = 7'b1101111;
    localparam bit [6:0] OP_JR = 7'b1100111;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_d;
    logic [3:0]  flags_m;
    logic        s0, s9, s3, s1, s5, s6, s7, s8, s2;
    logic [2:0]  s4;
    logic        stall_f, stall_d, flush_d, flush_e, flush_m;
`ifdef CORE_CTRL_PERF_EN
    logic [31:0] perf_cycles, perf_retired, perf_stalls, perf_flushes;
`endif

    core_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .instr_d (instr_d),
        .flags_m (flags_m),
        .s0      (s0),
        .s9      (s9),
        .s3      (s3),
        .s4      (s4),
        .s1      (s1),
        .s5      (s5),
        .s6      (s6),
        .s7      (s7),
        .s8      (s8),
        .s2      (s2),
        .stall_f (stall_f),
        .stall_d (stall_d),
        .flush_d (flush_d),
        .flush_e (flush_e),
        .flush_m (flush_m)
`ifdef CORE_CTRL_PERF_EN
        ,
        .perf_cycles  (perf_cycles),
        .perf_retired (perf_retired),
        .perf_stalls  (perf_stalls),
        .perf_flushes (perf_flushes)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        bit       v, wr, u1, u2, imm, st, ld, br, jal, jalr, s0, s9;
        bit [4:0] rd, rs1, rs2;
        bit [2:0] alu, f3;
    } info_t;

    int unsigned ncmp = 0;
    int unsigned nerr = 0;

    // Model: instruction words resident in E, M, W plus fetch queue
    bit [31:0] pw[3];
    bit        pv[3];
    bit [31:0] cur;
    bit [31:0] prog[$];
    bit        m_redir, m_stall, m_wv;
    bit [31:0] cyc, ret, stc, flc;

    function automatic bit [31:0] enc_i(bit [11:0] imm, bit [4:0] rs1, bit [2:0] f3, bit [4:0] rd, bit [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic bit [31:0] enc_r(bit alt, bit [4:0] rs2, bit [4:0] rs1, bit [2:0] f3, bit [4:0] rd, bit [6:0] op);
        return {1'b0, alt, 5'b0, rs2, rs1, f3, rd, op};
    endfunction

    function automatic info_t mdec(bit [31:0] w);
        info_t m;
        bit    is_op;
        m = '0;
        m.rd = w[11:7]; m.rs1 = w[19:15]; m.rs2 = w[24:20]; m.f3 = w[14:12];
        case (w[6:0])
            OP_R, OP_I: begin
                is_op = (w[6:0] == OP_R);
                m.v = 1; m.wr = 1; m.u1 = 1; m.u2 = is_op; m.imm = !is_op;
                case (m.f3)
                    3'd0: m.alu = (is_op && w[30]) ? 3'd1 : 3'd0;
                    3'd1: m.alu = 3'd6;
                    3'd2: m.alu = 3'd5;
                    3'd4: m.alu = 3'd4;
                    3'd5: begin m.alu = 3'd7; if (w[30]) m.v = 0; end
                    3'd6: m.alu = 3'd3;
                    3'd7: m.alu = 3'd2;
                    default: m.v = 0;
                endcase
            end
            OP_LD: begin m.v = 1; m.wr = 1; m.ld = 1; m.u1 = 1; m.imm = 1; end
            OP_ST: begin m.v = 1; m.st = 1; m.u1 = 1; m.u2 = 1; m.imm = 1; m.s0 = 1; end
            OP_BR: begin m.v = 1; m.br = 1; m.u1 = 1; m.u2 = 1; m.s0 = 1; m.alu = 3'd1; end
            OP_JL: begin m.v = 1; m.wr = 1; m.jal = 1; m.s9 = 1; end
            OP_JR: begin m.v = 1; m.wr = 1; m.jalr = 1; m.u1 = 1; m.imm = 1; end
            default: m.v = 0;
        endcase
        if (!m.v) m = '0;
        return m;
    endfunction

    function automatic info_t stage(int k);
        return pv[k] ? mdec(pw[k]) : '0;
    endfunction

    function automatic bit taken(bit [2:0] f3, bit [3:0] fl);
        bit n, z, c, v;
        {n, z, c, v} = fl;
        case (f3)
            3'd0: return z;
            3'd1: return !z;
            3'd4: return n != v;
            3'd5: return n == v;
            3'd6: return !c;
            3'd7: return c;
            default: return 0;
        endcase
    endfunction

    function automatic bit [31:0] rnd_instr();
        bit [4:0]  rd, ra, rb;
        bit [2:0]  f3;
        bit [11:0] imm;
        rd  = 5'($urandom_range(0, 3));
        ra  = 5'($urandom_range(0, 3));
        rb  = 5'($urandom_range(0, 3));
        f3  = 3'($urandom);
        imm = 12'($urandom);
        case ($urandom_range(0, 9))
            0: return enc_r(($urandom_range(0, 3) == 0), rb, ra, f3, rd, OP_R);
            1: return enc_i(imm, ra, f3, rd, OP_I);
            2: return enc_i(imm, ra, 3'd2, rd, OP_LD);
            3: return enc_r(0, rb, ra, 3'd2, 5'd0, OP_ST);
            4: return enc_r(0, rb, ra, f3, 5'd0, OP_BR);
            5: return {20'($urandom), rd, OP_JL};
            6: return enc_i(imm, ra, 3'd0, rd, OP_JR);
            7: return $urandom;
            default: return enc_i(imm, ra, 3'd0, rd, OP_I);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {15'd0, s0, s9, s3, s4, s1, s5, s6, s7, s8, s2,
                  stall_f, stall_d, flush_d, flush_e, flush_m}, 32'd0);
`ifdef CORE_CTRL_PERF_EN
        chk({tag, "_perf"}, perf_cycles | perf_retired | perf_stalls | perf_flushes, 32'd0);
`endif
    endtask

    // Drive D-stage inputs just after an edge and compare at the falling edge
    task automatic settle(input bit [3:0] fl);
        info_t d, e, m, w, p;
        bit    haz;
        instr_d = cur;
        flags_m = fl;
        #4;
        d = mdec(cur); e = stage(0); m = stage(1); w = stage(2);
        m_redir = m.v && (m.jal || m.jalr || (m.br && taken(m.f3, fl)));
        haz = 0;
        for (int k = 0; k < 3; k++) begin
            p = stage(k);
            if (p.v && p.wr && p.rd != 0 &&
                ((d.u1 && d.rs1 == p.rd) || (d.u2 && d.rs2 == p.rd))) haz = 1;
        end
        m_stall = haz && !m_redir;
        m_wv    = w.v;
        chk("s0", s0, d.s0);
        chk("s9", s9, d.s9);
        chk("s3", s3, e.imm);
        chk("s4", s4, e.alu);
        chk("s1", s1, m_redir);
        chk("s5", s5, m.st);
        chk("s6", s6, m.br || m.jal);
        chk("s7", s7, w.ld);
        chk("s8", s8, w.wr && !w.jal && !w.jalr);
        chk("s2", s2, w.wr && w.rd != 0);
        chk("stall_f", stall_f, m_stall);
        chk("stall_d", stall_d, m_stall);
        chk("flush_d", flush_d, m_redir);
        chk("flush_e", flush_e, m_redir || m_stall);
        chk("flush_m", flush_m, m_redir);
`ifdef CORE_CTRL_PERF_EN
        chk("perf_cycles", perf_cycles, cyc);
        chk("perf_retired", perf_retired, ret);
        chk("perf_stalls", perf_stalls, stc);
        chk("perf_flushes", perf_flushes, flc);
`endif
    endtask

    task automatic advance();
        @(posedge clk);
        cyc++;
        if (m_wv)    ret++;
        if (m_stall) stc++;
        if (m_redir) flc++;
        pv[2] = pv[1]; pw[2] = pw[1];
        if (m_redir) pv[1] = 0;
        else begin pv[1] = pv[0]; pw[1] = pw[0]; end
        if (m_redir || m_stall) pv[0] = 0;
        else begin pv[0] = 1; pw[0] = cur; end
        if (!m_stall) begin
            if (m_redir) begin
                cur = 32'd0;
                if (prog.size() > 0) void'(prog.pop_front());
            end else begin
                cur = (prog.size() > 0) ? prog.pop_front() : 32'd0;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            settle(4'd0);
            advance();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk_zero("reset_async");
        for (int k = 0; k < 3; k++) pv[k] = 0;
        cyc = 0; ret = 0; stc = 0; flc = 0;
        m_redir = 0; m_stall = 0; m_wv = 0;
        prog.delete();
        cur = 32'd0;
        @(posedge clk);
        #1 instr_d = $urandom;
        #3 chk_zero("reset_hold_mid");
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        int          ns, nfe, s2cyc, n1, nf3, n2, n5, n6, n7;
        bit          st_at_redir, fd_at_redir;
        logic [31:0] pf0;

        reset   = 1'b1;
        instr_d = $urandom;
        flags_m = 4'($urandom);
        cur     = 32'd0;
        cyc = 0; ret = 0; stc = 0; flc = 0;
        for (int k = 0; k < 3; k++) begin pv[k] = 0; pw[k] = 0; end
        m_redir = 0; m_stall = 0; m_wv = 0;
        pf0 = 0;
        repeat (3) begin
            @(posedge clk);
            #1 instr_d = $urandom;
            flags_m = 4'($urandom);
            #3 chk_zero("reset_hold");
        end
        @(posedge clk);
        #1 reset = 1'b0;

        // ADDI x1,x0,5: EX selects one cycle later, writeback three later
        cur = enc_i(12'd5, 5'd0, 3'd0, 5'd1, OP_I);
        settle(4'd0);
        chk("t1_s0", s0, 0);
        advance();
        settle(4'd0);
        chk("t1_s3", s3, 1);
        chk("t1_s4", s4, 0);
        advance();
        settle(4'd0);
        advance();
        settle(4'd0);
        chk("t1_s2", s2, 1);
        chk("t1_s8", s8, 1);
        advance();
        idle(4);

        // Back-to-back RAW: three stall cycles, consumer writes back at cycle 7
        cur = enc_i(12'd5, 5'd0, 3'd0, 5'd1, OP_I);
        prog.push_back(enc_r(0, 5'd1, 5'd1, 3'd0, 5'd2, OP_R));
        ns = 0; nfe = 0; s2cyc = -1;
        for (int i = 0; i < 10; i++) begin
            settle(4'd0);
            if (stall_d) ns++;
            if (stall_d && flush_e) nfe++;
            if (s2) s2cyc = i;
            advance();
        end
        chk("t2_stalls", ns, 3);
        chk("t2_flush_e", nfe, 3);
        chk("t2_s2_cycle", s2cyc, 7);
        idle(3);

        // x0 is never a hazard and never written
        cur = enc_i(12'd1, 5'd0, 3'd0, 5'd0, OP_I);
        prog.push_back(enc_r(0, 5'd0, 5'd0, 3'd0, 5'd2, OP_R));
        ns = 0; n2 = 0;
        for (int i = 0; i < 8; i++) begin
            settle(4'd0);
            if (stall_d) ns++;
            if (s2) n2++;
            advance();
        end
        chk("t3_stalls", ns, 0);
        chk("t3_s2_count", n2, 1);

        // Taken BEQ kills the three younger instructions
        cur = enc_r(0, 5'd0, 5'd0, 3'd0, 5'd0, OP_BR);
        prog.push_back(enc_i(12'd1, 5'd0, 3'd0, 5'd5, OP_I));
        prog.push_back(enc_r(0, 5'd0, 5'd0, 3'd2, 5'd0, OP_ST));
        prog.push_back(enc_i(12'd1, 5'd0, 3'd0, 5'd6, OP_I));
        n1 = 0; nf3 = 0; n2 = 0; n5 = 0; n6 = 0;
        for (int i = 0; i < 8; i++) begin
            settle(4'b0100);
            if (s1) n1++;
            if (s1 && s6) n6++;
            if (flush_d && flush_e && flush_m) nf3++;
            if (s2) n2++;
            if (s5) n5++;
            advance();
        end
        chk("t4_s1_count", n1, 1);
        chk("t4_s6_with_s1", n6, 1);
        chk("t4_flush_count", nf3, 1);
        chk("t4_killed_s2", n2, 0);
        chk("t4_killed_s5", n5, 0);

        // BNE not taken with Z set, then LW/SW selects
        cur = enc_r(0, 5'd0, 5'd0, 3'd1, 5'd0, OP_BR);
        n1 = 0; nf3 = 0;
        for (int i = 0; i < 6; i++) begin
            settle(4'b0100);
            if (s1) n1++;
            if (flush_d) nf3++;
            advance();
        end
        chk("t5_bne_s1", n1, 0);
        chk("t5_bne_flush", nf3, 0);
        cur = enc_i(12'd0, 5'd0, 3'd2, 5'd7, OP_LD);
        prog.push_back(enc_r(0, 5'd0, 5'd0, 3'd2, 5'd0, OP_ST));
        n7 = 0; n5 = 0;
        for (int i = 0; i < 8; i++) begin
            settle(4'd0);
            if (s7) n7++;
            if (s5) n5++;
            advance();
        end
        chk("t5_s7_count", n7, 1);
        chk("t5_s5_count", n5, 1);

        // Redirect while D is stalled: flushes win over the stall
        cur = enc_i(12'd1, 5'd0, 3'd0, 5'd1, OP_I);
        prog.push_back(enc_r(0, 5'd0, 5'd0, 3'd0, 5'd0, OP_BR));
        prog.push_back(enc_r(0, 5'd1, 5'd1, 3'd0, 5'd2, OP_R));
        n1 = 0; st_at_redir = 1; fd_at_redir = 0;
        for (int i = 0; i < 8; i++) begin
            settle(4'b0100);
`ifdef CORE_CTRL_PERF_EN
            if (i == 0) pf0 = perf_flushes;
`endif
            if (s1) begin
                n1++;
                st_at_redir = stall_d;
                fd_at_redir = flush_d;
            end
            advance();
        end
        chk("t6_s1_count", n1, 1);
        chk("t6_stall_at_redir", st_at_redir, 0);
        chk("t6_flush_at_redir", fd_at_redir, 1);
        settle(4'd0);
`ifdef CORE_CTRL_PERF_EN
        chk("t6_perf_flush_delta", perf_flushes - pf0, 1);
`endif
        advance();

        // Random streams with a reset in the middle
        for (int i = 0; i < 3000; i++) begin
            while (prog.size() < 4) prog.push_back(rnd_instr());
            settle(4'($urandom));
            if (i == 1500) do_reset();
            else advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/core_ctrl.md
# core_ctrl

Pipeline controller for the five-stage RV32 core: decodes the instruction held in the IF/DEC register and generates every datapath select (S0–S9). It carries per-stage control bits alongside the EX, MEM and WB pipeline registers, and resolves branches from the MEM-stage flags. It also detects register RAW hazards and drives stall/flush for the fetch and pipeline registers, since the datapath has no forwarding.

## Interface
Parameters: none.

Clock and reset:
- clk  in  1  core clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all control state

Inputs:
- instr_d  in  32  instruction in DEC (IF/DEC output)
- flags_m  in  4  ALU flags in MEM: [3]N [2]Z [1]C [0]V; C=1 means no borrow

DEC-stage selects (combinational from instr_d):
- s0  out  1  immediate form select, instr[31:25]
- s9  out  1  20-bit immediate select

EX-stage selects:
- s3  out  1  ALU SrcB = Imm
- s4  out  3  ALU control

MEM-stage selects:
- s1  out  1  PC redirect
- s5  out  1  DM write enable
- s6  out  1  redirect target = ADDPC (else ALUResult)

WB-stage selects:
- s7  out  1  WB source = DM read data
- s8  out  1  WB = MUX7 (else PC4)
- s2  out  1  register-file write enable

Pipeline control:
- stall_f, stall_d  out  1  hold PC / IF-DEC
- flush_d, flush_e, flush_m  out  1  bubble IF-DEC / DEC-EX / EX-MEM

## Operation
- Supported opcodes (others decode as bubble: no writes, no redirect):
  - OP 0110011, OP-IMM 0010011
  - LOAD 0000011, STORE 0100011
  - BRANCH 1100011, JAL 1101111, JALR 1100111
- ALU codes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SLL, 111 SRL.
- funct3 mapping: 000 ADD (SUB for OP with funct7[5]), 001 SLL, 010 SLT, 100 XOR, 101 SRL, 110 OR, 111 AND. funct3 011 or funct7[5] on SRL decodes as bubble.
- Per-class control:
  - LOAD/STORE/JALR: ALU ADD, s3=1.
  - BRANCH: SUB, s3=0.
  - STORE and BRANCH: s0=1. JAL: s9=1.
  - LOAD: s7=1.
  - JAL/JALR: s8=0. All other writing classes: s8=1.
- Control bundle per stage: valid, regwrite, rd[4:0], memwrite, memtoreg, wbsel, alusrc, aluctl, branch, funct3, jump, jal.
  - Bundle advances D→E→M→W each cycle.
  - A stage output is driven only when that stage's valid=1.
- s2 = W.valid & W.regwrite & (W.rd≠0).
- s5 = M.valid & M.memwrite.
- Branch taken conditions (from funct3 and flags_m):
  - BEQ: Z. BNE: !Z.
  - BLT: N^V. BGE: !(N^V).
  - BLTU: !C. BGEU: C.
- Redirect: s1 = M.valid & (jump | branch taken). s6=1 for branch/JAL, 0 for JALR.
- Hazard scoreboard: stall when D reads a register (rs1, and rs2 for OP/STORE/BRANCH) that is nonzero and equals the rd of any valid regwrite bundle in E, M or W.
- On stall:
  - stall_f = stall_d = flush_e = 1.
  - A bubble enters E.
- On redirect: flush_d = flush_e = flush_m = 1, stall_f = stall_d = 0.
- Priority: redirect beats stall.

## Timing
- Instruction in D at cycle n occupies E at n+1, M at n+2, W at n+3.
- s0/s9 are valid in cycle n; E/M/W selects follow with the same alignment.
- RAW penalty vs a producer k stages ahead (E=1, M=2, W=3): 4−k stall cycles. Back-to-back dependency costs 3.
- Redirect taken in cycle t: the three younger instructions (D, E, M input) are killed at edge t; the target is fetched at t+1. Penalty is 3 cycles.
- Reset: all bundle valid bits, counters and outputs = 0 immediately and asynchronously.
- Reset mid-operation discards in-flight instructions. No s2/s5 may assert until new instructions reach W/M.

## Configuration
- CORE_CTRL_PERF_EN defined: adds perf_cycles, perf_retired, perf_stalls and perf_flushes (out, 32 each).
  - Counters are cleared by reset and wrap at 2^32.
  - perf_retired increments when W.valid.
  - perf_stalls increments on stall_d.
  - perf_flushes increments per redirect.
- Undefined: no ports and no counter logic.

## Structure
- Package core_ctrl_pkg holds: opcode constants, ALU control codes, branch funct3 codes, and the ctrl_t bundle struct.
- Combinational decoder as sub-module core_ctrl_decode (instr_d → ctrl_t, s0, s9).
- Stage registers, scoreboard and branch resolution live in the top.

## Test plan
- Reset held with random instr_d → every output 0. Release, ADDI x1,x0,5 at n → s3=1, s4=000 at n+1; s2=1, s8=1 at n+3.
- ADDI x1 then ADD x2,x1,x1 → stall_d=1 for 3 cycles, flush_e each; s2 for x2 at n+6.
- ADDI x0,x0,1 then ADD x2,x0,x0 → no stall; s2=0 for the first.
- BEQ in M with flags_m=0100 → s1=1, s6=1, flush_d/e/m=1 for one cycle. The next three instructions never raise s2/s5.
- BNE with flags_m=0100 → s1=0, no flush. LW followed by SW → s7=1 at W, s5=1 at M.
- Taken branch in M while D is stalled → stall_d=0, flushes win. With CORE_CTRL_PERF_EN, perf_flushes increments by 1.
